prio_encoder_pipe: RTL
======================

// Module: prio_encoder_pipe
// PURPOSE
//   Registered N-to-log2(N) priority encoder; inverse of the 2-to-4 line decoder.
//   Maps a one-hot line vector D back to its binary select code S (D=4'b0100 -> S=2'b10).
//   Valid/ready on both sides, a 2-entry skid buffer, and flags for zero- and multi-hot inputs.
//   Sits between one-hot producers (grant/select lines) and logic that consumes binary selects.
// PARAMETERS
//   N      4   input line count; power of two, >= 2
//   W      2   code width; must equal $clog2(N)
//   CNT_W  8   width of the saturating multi-hot error counter
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      D holds a valid line vector
//   in_ready   out  1      block can accept D this cycle
//   D          in   N      line vector to encode
//   out_valid  out  1      S and the flags are valid
//   out_ready  in   1      downstream accepts S this cycle
//   S          out  W      encoded select code
//   out_zero   out  1      accepted D was all zeros (S = 0)
//   out_multi  out  1      accepted D had more than one bit set
//   err_count  out  CNT_W  saturating count of accepted multi-hot vectors
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): out_valid=0, S=0, out_zero=0, out_multi=0, err_count=0,
//     both skid entries empty, in_ready=1 on the first cycle after release.
//   Encoding: S = index of the highest set bit of D.
//     out_zero=1 iff D==0, and then S=0. out_multi=1 iff popcount(D)>1.
//   Input accept: in_valid & in_ready. Output transfer: out_valid & out_ready.
//   Latency: 1 cycle. A vector accepted at edge k is presented at edge k+1 when the output
//     register is empty or is transferring at the same edge.
//   Storage: output register (OR) plus skid register (SK).
//     in_ready is registered: in_ready = !SK_full. It never depends combinationally on out_ready.
//   State by occupancy: EMPTY (OR and SK empty), ONE (OR full), TWO (OR and SK full).
//     EMPTY: accept -> ONE.
//     ONE: accept with transfer -> ONE (OR reloads). Accept without transfer -> TWO (to SK).
//       Transfer without accept -> EMPTY.
//     TWO: in_ready=0. Transfer -> ONE (SK moves into OR).
//   Ordering is strictly FIFO. No entry is dropped or duplicated.
//   While out_valid=1 and out_ready=0: S, out_zero and out_multi hold stable.
//   in_valid while in_ready=0: D is ignored, with no side effects.
//   err_count: increments at the edge where a multi-hot D is accepted; it counts at accept,
//     not at output. It saturates at 2^CNT_W-1 and never wraps. It clears only on reset.
//   Reset asserted mid-operation: all contents are discarded immediately and the block
//     returns to EMPTY. There is no partial output.
// STRUCTURE
//   Package prio_enc_pkg:
//     - localparams for the default N/W/CNT_W
//     - function enc_hi(D) -> {zero, multi, code}, shared with other one-hot consumers
//   Sub-module prio_enc_skid: a generic 2-entry valid/ready skid buffer of width W+2.
//     The top level instantiates the encode function in front of it, plus the error counter.
//   Elaboration check: fatal if W != $clog2(N).
// TESTING
//   1. Sweep D=0001,0010,0100,1000 with out_ready=1
//      -> S=00,01,10,11, each appearing 1 cycle after accept.
//   2. Round trip: drive the 2-to-4 decoder with S=00,01,10,11,00,11 and feed its D here
//      -> S out equals S in, with out_zero=0 and out_multi=0 throughout.
//   3. D=0000 -> S=00, out_zero=1. D=0110 -> S=10, out_multi=1, err_count 0->1.
//   4. Backpressure: hold out_ready=0 and offer 0001,0100,1000
//      -> the first two are stored and in_ready=0 with 1000 pending.
//      Then raise out_ready -> S=00, then 10, then 11, in order with no loss.
//   5. Saturation with CNT_W=2: accept five vectors of D=1111 -> err_count=3 and holds.
//   6. Pull rst_n low while in state TWO
//      -> out_valid=0 and err_count=0 asynchronously; after release in_ready=1 and state is EMPTY.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered priority encoder and other one-hot consumers.
// enc_hi() works on a zero-extended vector of up to ENC_MAX_N lines.
package prio_enc_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_W     = 2;
  localparam int DEF_CNT_W = 8;

  localparam int ENC_MAX_N = 64;
  localparam int ENC_MAX_W = $clog2(ENC_MAX_N);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } skid_state_t;

  typedef struct packed {
    logic                 zero;
    logic                 multi;
    logic [ENC_MAX_W-1:0] code;
  } enc_res_t;

  // Highest set bit wins; multi is raised as soon as a second set bit is seen.
  function automatic enc_res_t enc_hi(input logic [ENC_MAX_N-1:0] d);
    enc_res_t r;
    logic     seen;
    r.zero  = 1'b1;
    r.multi = 1'b0;
    r.code  = '0;
    seen    = 1'b0;
    for (int i = 0; i < ENC_MAX_N; i++) begin
      if (d[i]) begin
        r.multi = r.multi | seen;
        seen    = 1'b1;
        r.zero  = 1'b0;
        r.code  = ENC_MAX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_encoder_pipe_if.sv
// Valid/ready line-vector input and select-code output of the priority encoder.
// slave is the encoder's view, master is the producer/consumer side.
interface prio_encoder_pipe_if #(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     D;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     S;
  logic             out_zero;
  logic             out_multi;
  logic [CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, out_zero, out_multi, err_count
  );

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, out_zero, out_multi, err_count
  );
endinterface

// File: rtl/prio_enc_skid.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid register.
// in_ready comes straight from a flop so upstream never sees a path from out_ready.
module prio_enc_skid
  import prio_enc_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_t   state_reg, state_next;
  logic          in_ready_reg;
  logic [DW-1:0] or_data_reg;
  logic [DW-1:0] sk_data_reg;
  logic          accept, xfer;
  logic          or_load_in, or_load_sk, sk_load;

  assign accept = in_valid & in_ready_reg;
  assign xfer   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_TWO);
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_EMPTY: if (accept) state_next = ST_ONE;
      ST_ONE: begin
        if (accept && !xfer)      state_next = ST_TWO;
        else if (!accept && xfer) state_next = ST_EMPTY;
      end
      ST_TWO:   if (xfer) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid  = (state_reg != ST_EMPTY);
    or_load_in = 1'b0;
    or_load_sk = 1'b0;
    sk_load    = 1'b0;
    unique case (state_reg)
      ST_EMPTY: or_load_in = accept;
      ST_ONE: begin
        or_load_in = accept & xfer;
        sk_load    = accept & ~xfer;
      end
      ST_TWO:   or_load_sk = xfer;
      default: begin
        or_load_in = 1'b0;
      end
    endcase
  end

  // Per-bit storage lanes; OR takes either the fresh input or the skid entry.
  for (genvar gi = 0; gi < DW; gi++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        or_data_reg[gi] <= 1'b0;
        sk_data_reg[gi] <= 1'b0;
      end else begin
        if (or_load_in)      or_data_reg[gi] <= in_data[gi];
        else if (or_load_sk) or_data_reg[gi] <= sk_data_reg[gi];
        if (sk_load)         sk_data_reg[gi] <= in_data[gi];
      end
    end
  end

  assign in_ready = in_ready_reg;
  assign out_data = or_data_reg;

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-to-log2(N) priority encoder with zero/multi-hot flags, skid-buffered
// valid/ready handshake and a saturating count of accepted multi-hot vectors.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  prio_encoder_pipe_if.slave bus
);

  if (W != $clog2(N)) begin : g_bad_w
    $fatal(1, "prio_encoder_pipe: W must equal clog2(N)");
  end
  if (N < 2 || N > ENC_MAX_N) begin : g_bad_n
    $fatal(1, "prio_encoder_pipe: N out of supported range");
  end

  logic [ENC_MAX_N-1:0] d_ext;
  enc_res_t             enc;
  logic                 enc_code_unused;
  logic [W+1:0]         skid_din, skid_dout;
  logic                 in_ready;
  logic                 accept;
  logic [CNT_W-1:0]     err_count_reg, err_count_next;

  for (genvar gi = 0; gi < ENC_MAX_N; gi++) begin : g_dext
    if (gi < N) begin : g_live
      assign d_ext[gi] = bus.D[gi];
    end else begin : g_pad
      assign d_ext[gi] = 1'b0;
    end
  end

  assign enc             = enc_hi(d_ext);
  assign enc_code_unused = ^enc.code;
  assign skid_din        = {enc.zero, enc.multi, enc.code[W-1:0]};

  prio_enc_skid #(.DW(W + 2)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready),
    .in_data   (skid_din),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (skid_dout)
  );

  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;
  assign bus.out_zero = skid_dout[W+1];
  assign bus.out_multi = skid_dout[W];
  assign bus.S        = skid_dout[W-1:0];

  // Counted on accept, so a stalled output does not delay the error statistic.
  always_comb begin
    err_count_next = err_count_reg;
    if (accept && enc.multi && (err_count_reg != {CNT_W{1'b1}}))
      err_count_next = err_count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_reg <= '0;
    else        err_count_reg <= err_count_next;
  end

  assign bus.err_count = err_count_reg;

endmodule
